draw_sprite_fill: RTL and testbench
===================================

DRAW_SPRITE_FILL -- requirements
Module: draw_sprite_fill

Interface
REQ-001 Parameter SPR_W, default 137, sprite width in pixels (columns 0..SPR_W-1).
REQ-002 Parameter SPR_H, default 37, sprite height in pixels (rows 0..SPR_H-1).
REQ-003 Parameter ADDR_W, default 13, ROM address width; SPR_W*SPR_H SHALL be <= 2**ADDR_W.
REQ-004 Parameter KEY_COLOUR, default 3'b000, transparent colour code.
REQ-005 clock_all  in  1  single clock; all state changes on its rising edge.
REQ-006 reset_all  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  draw request; sampled only in IDLE.
REQ-008 x_  in  9  origin x; latched at accepted start.
REQ-009 y_  in  8  origin y; latched at accepted start.
REQ-010 fill_cols  in  9  columns taken from ROM; columns >= fill_cols use empty_colour; latched at start.
REQ-011 empty_colour  in  3  colour for unfilled columns; latched at start.
REQ-012 key_en  in  1  enables KEY_COLOUR transparency; latched at start.
REQ-013 rom_addr  out  ADDR_W  sprite ROM read address.
REQ-014 rom_q  in  3  ROM data; valid one cycle after rom_addr is presented (synchronous ROM).
REQ-015 out_x / out_y / out_colour  out  9/8/3  pixel coordinate and colour to the VGA adapter.
REQ-016 plot  out  1  high when out_x/out_y/out_colour form a pixel to write.
REQ-017 busy  out  1  high in RUN and FLUSH.
REQ-018 done  out  1  one-cycle pulse on completion.

Function
REQ-019 FSM SHALL have states IDLE, RUN, FLUSH, DONE.
REQ-020 IDLE: start=1 at edge E0 -> latch x_, y_, fill_cols, empty_colour, key_en; col=0, row=0, rom_addr=0; go RUN.
REQ-021 RUN: rom_addr = row*SPR_W+col, kept as an incrementing counter (no multiplier); col increments each cycle, wraps to 0 at SPR_W-1 with row+1.
REQ-022 Address for pixel k SHALL be presented in the cycle after edge E_k; pixel k SHALL appear on outputs in the cycle after E_(k+1) (one-cycle pipeline stage carrying col/row/valid, aligned with rom_q).
REQ-023 RUN at col=SPR_W-1, row=SPR_H-1 -> FLUSH at next edge; FLUSH presents final pixel, then DONE; DONE asserts done for exactly one cycle, then IDLE.
REQ-024 Total time start edge to done cycle: SPR_W*SPR_H+1 edges; plot asserted on at most SPR_W*SPR_H cycles per draw.
REQ-025 out_x = x0+col mod 512, out_y = y0+row mod 256 (wrap, no saturation).
REQ-026 out_colour = rom_q when col < fill_cols, else empty_colour; fill_cols >= SPR_W SHALL behave as SPR_W; fill_cols=0 -> every pixel empty_colour.
REQ-027 plot = pipeline valid AND NOT (key_en AND col < fill_cols AND rom_q == KEY_COLOUR); empty_colour pixels are never keyed.
REQ-028 start while busy or in DONE SHALL be ignored; start in the cycle done is high SHALL be ignored.
REQ-029 Outside RUN/FLUSH plot=0; rom_addr, out_x, out_y, out_colour SHALL be 0 in IDLE.
REQ-030 Inputs x_, y_, fill_cols, empty_colour, key_en changing mid-draw SHALL NOT affect the current draw.

Reset
REQ-031 reset_all=0 SHALL immediately force IDLE, col=row=0, rom_addr=0, pipeline valid=0, plot=0, busy=0, done=0, out_x=out_y=out_colour=0, latched registers 0.
REQ-032 Reset mid-draw SHALL abort without a done pulse; first start after release SHALL begin a fresh draw from pixel 0.

Verification (SPR_W=4, SPR_H=2, ROM word k = k mod 8)
REQ-033 start, x_=10, y_=20, fill_cols=4, key_en=0 -> 8 plot cycles, (10,20,c0)...(13,21,c7) in raster order, done exactly 9 edges after start edge, busy low with done.
REQ-034 fill_cols=2, empty_colour=3'b101 -> columns 0,1 show ROM colour, columns 2,3 show 101 on both rows.
REQ-035 key_en=1, KEY_COLOUR=0 -> pixel 0 (colour 000) has plot=0; other 7 plot=1; fill_cols=0 with key_en=1 -> all 8 plot=1, colour=empty_colour.
REQ-036 x_=510, y_=255 -> out_x sequence 510,511,0,1; row 1 out_y=0.
REQ-037 start pulsed during RUN and during DONE -> ignored, single done; reset_all low at pixel 3 -> outputs 0 asynchronously, no done; later start -> full 8-pixel draw.

Source files
------------

// File: rtl/draw_sprite_fill.sv
// Sprite blitter: reads a SPR_W x SPR_H sprite from a synchronous ROM and plots it at (x0,y0),
// with columns at or beyond fill_cols drawn in a flat colour and optional colour-key transparency.
module draw_sprite_fill #(
    parameter int          SPR_W      = 137,
    parameter int          SPR_H      = 37,
    parameter int          ADDR_W     = 13,
    parameter logic [2:0]  KEY_COLOUR = 3'b000
) (
    input  logic              clock_all,
    input  logic              reset_all,
    input  logic              start,
    input  logic [8:0]        x_,
    input  logic [7:0]        y_,
    input  logic [8:0]        fill_cols,
    input  logic [2:0]        empty_colour,
    input  logic              key_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_q,
    output logic [8:0]        out_x,
    output logic [7:0]        out_y,
    output logic [2:0]        out_colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t      state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // one pipeline stage that lines the pixel position up with rom_q
    logic          p_vld;
    logic [CW-1:0] p_col;
    logic [RW-1:0] p_row;

    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] fill_l;
    logic [2:0] empty_l;
    logic       key_l;

    always_ff @(posedge clock_all or negedge reset_all) begin
        if (!reset_all) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            p_vld    <= 1'b0;
            p_col    <= '0;
            p_row    <= '0;
            x0       <= '0;
            y0       <= '0;
            fill_l   <= '0;
            empty_l  <= '0;
            key_l    <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    p_vld <= 1'b0;
                    if (start) begin
                        x0       <= x_;
                        y0       <= y_;
                        fill_l   <= fill_cols;
                        empty_l  <= empty_colour;
                        key_l    <= key_en;
                        col      <= '0;
                        row      <= '0;
                        rom_addr <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    p_vld <= 1'b1;
                    p_col <= col;
                    p_row <= row;
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            // ROM has already sampled the last address on this edge
                            row      <= '0;
                            rom_addr <= '0;
                            state    <= FLUSH;
                        end else begin
                            row      <= row + RW'(1);
                            rom_addr <= rom_addr + ADDR_W'(1);
                        end
                    end else begin
                        col      <= col + CW'(1);
                        rom_addr <= rom_addr + ADDR_W'(1);
                    end
                end
                FLUSH: begin
                    p_vld <= 1'b0;
                    p_col <= '0;
                    p_row <= '0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // col < SPR_W always, so fill_cols >= SPR_W naturally fills every column
    logic in_fill;
    assign in_fill = 16'(p_col) < 16'(fill_l);

    assign busy       = (state == RUN) || (state == FLUSH);
    assign out_x      = p_vld ? (x0 + 9'(p_col)) : 9'd0;
    assign out_y      = p_vld ? (y0 + 8'(p_row)) : 8'd0;
    assign out_colour = !p_vld ? 3'd0 : (in_fill ? rom_q : empty_l);
    assign plot       = p_vld && !(key_l && in_fill && (rom_q == KEY_COLOUR));

endmodule

// File: tb/tb_draw_sprite_fill.sv
// Randomized bench for draw_sprite_fill on a 4x2 sprite, checked against a per-pixel reference model.
module tb_draw_sprite_fill;

    localparam int SW = 4;
    localparam int SH = 2;
    localparam int N  = SW * SH;
    localparam int AW = 3;

    logic          clock_all = 1'b0;
    logic          reset_all = 1'b0;
    logic          start = 1'b0;
    logic [8:0]    x_ = '0;
    logic [7:0]    y_ = '0;
    logic [8:0]    fill_cols = '0;
    logic [2:0]    empty_colour = '0;
    logic          key_en = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [2:0]    rom_q = '0;
    logic [8:0]    out_x;
    logic [7:0]    out_y;
    logic [2:0]    out_colour;
    logic          plot, busy, done;

    logic [2:0] rom_mem [N];

    int n_chk  = 0;
    int n_pass = 0;

    draw_sprite_fill #(.SPR_W(SW), .SPR_H(SH), .ADDR_W(AW), .KEY_COLOUR(3'b000)) dut (
        .clock_all(clock_all), .reset_all(reset_all), .start(start),
        .x_(x_), .y_(y_), .fill_cols(fill_cols), .empty_colour(empty_colour),
        .key_en(key_en), .rom_addr(rom_addr), .rom_q(rom_q),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock_all = ~clock_all;

    // synchronous sprite ROM
    always @(posedge clock_all) rom_q <= rom_mem[rom_addr];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic scramble_inputs();
        x_           = 9'($urandom);
        y_           = 8'($urandom);
        fill_cols    = 9'($urandom);
        empty_colour = 3'($urandom);
        key_en       = 1'($urandom);
    endtask

    // rst_at < 0: run to completion; otherwise pull reset after sampling cycle rst_at
    task automatic run_draw(input int x, input int y, input int fill, input int empty,
                            input bit key, input bit jam, input int rst_at);
        int col, row, ec, ex, ey;
        bit inf, ep;
        @(negedge clock_all);
        x_ = 9'(x); y_ = 8'(y); fill_cols = 9'(fill);
        empty_colour = 3'(empty); key_en = key; start = 1'b1;
        for (int j = 0; j <= N + 2; j++) begin
            @(negedge clock_all);
            if (j == 0) begin
                chk("busy_first", busy, 1);
                chk("plot_first", plot, 0);
                chk("addr_first", rom_addr, 0);
            end else if (j <= N) begin
                col = (j - 1) % SW;
                row = (j - 1) / SW;
                inf = col < fill;
                ec  = inf ? rom_mem[j - 1] : empty;
                ep  = !(key && inf && rom_mem[j - 1] == 3'b000);
                ex  = (x + col) % 512;
                ey  = (y + row) % 256;
                chk($sformatf("x_px%0d", j - 1), out_x, ex);
                chk($sformatf("y_px%0d", j - 1), out_y, ey);
                chk($sformatf("col_px%0d", j - 1), out_colour, ec);
                chk($sformatf("plot_px%0d", j - 1), plot, ep);
                chk($sformatf("busy_px%0d", j - 1), busy, 1);
                chk("done_early", done, 0);
            end else if (j == N + 1) begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 0);
                chk("plot_at_done", plot, 0);
            end else begin
                chk("done_one_cycle", done, 0);
                chk("busy_after", busy, 0);
                chk("addr_idle", rom_addr, 0);
                chk("outx_idle", out_x, 0);
                chk("colour_idle", out_colour, 0);
            end
            if (j == rst_at) begin
                reset_all = 1'b0;
                #1;
                chk("rst_plot", plot, 0);
                chk("rst_busy", busy, 0);
                chk("rst_outx", out_x, 0);
                chk("rst_outy", out_y, 0);
                chk("rst_colour", out_colour, 0);
                chk("rst_addr", rom_addr, 0);
                start = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clock_all);
                    chk("rst_no_done", done, 0);
                end
                reset_all = 1'b1;
                return;
            end
            // mid-draw input changes must not disturb this draw
            scramble_inputs();
            if (jam && j <= N) start = 1'($urandom);
            else if (jam && j == N + 1) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) rom_mem[k] = 3'(k % 8);
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_plot", plot, 0);
        chk("reset_addr", rom_addr, 0);
        chk("reset_outx", out_x, 0);
        @(negedge clock_all);
        reset_all = 1'b1;

        run_draw(10, 20, 4, 0, 1'b0, 1'b0, -1);
        run_draw(10, 20, 2, 5, 1'b0, 1'b0, -1);
        run_draw(30, 40, 4, 2, 1'b1, 1'b0, -1);
        run_draw(30, 40, 0, 6, 1'b1, 1'b0, -1);
        run_draw(510, 255, 9, 1, 1'b0, 1'b0, -1);
        run_draw(1, 2, 4, 0, 1'b0, 1'b1, -1);
        run_draw(10, 20, 4, 0, 1'b0, 1'b0, 4);
        run_draw(10, 20, 4, 0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < N; k++) rom_mem[k] = 3'($urandom);
            run_draw($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 12),
                     $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 5) == 0) ? $urandom_range(1, N) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
